// File: rtl/chan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : chan_pkg
//  Purpose  : Shared types, constants and helpers for channel_err_inj.
//  Revision : 1.0  initial release
// ============================================================================
package chan_pkg;

   // Impairment mode selected at start.
   typedef enum logic [1:0] {
      PASS  = 2'b00,
      BURST = 2'b01,
      RAND  = 2'b10,
      RSVD  = 2'b11
   } mode_e;

   // Measurement-run controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Number of set bits in a 2-bit value.
   function automatic logic [1:0] popcount2(input logic [1:0] v);
      return {1'b0, v[1]} + {1'b0, v[0]};
   endfunction

   // One right-shifting Galois step.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/channel_err_inj_if.sv
`default_nettype none
// ============================================================================
//  Module   : channel_err_inj_if
//  Purpose  : Symbol stream and control/status bundle of the impairment stage.
//  Revision : 1.0  initial release
// ============================================================================
interface channel_err_inj_if;
   logic        start_i;
   logic [1:0]  mode_i;
   logic [7:0]  thresh_i;
   logic        valid_i;
   logic [1:0]  sym_i;
   logic        valid_o;
   logic [1:0]  sym_o;
   logic        busy_o;
   logic        done_o;
   logic [15:0] inj_ct_o;
   logic [15:0] bad_bit_ct_o;

   // Driver side: encoder / test controller.
   modport master (
      output start_i, mode_i, thresh_i, valid_i, sym_i,
      input  valid_o, sym_o, busy_o, done_o, inj_ct_o, bad_bit_ct_o
   );

   // The impairment stage itself.
   modport slave (
      input  start_i, mode_i, thresh_i, valid_i, sym_i,
      output valid_o, sym_o, busy_o, done_o, inj_ct_o, bad_bit_ct_o
   );
endinterface
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr16
//  Purpose  : 16-bit Galois LFSR with synchronous load; load and advance in
//             the same cycle yields one step from the seed.
//  Revision : 1.0  initial release
// ============================================================================
module lfsr16
   import chan_pkg::*;
#(
   parameter logic [15:0] RESET_VAL = 16'hACE1
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        load,
   input  wire logic [15:0] seed,
   input  wire logic        advance,
   output      logic [15:0] q
);

   logic [15:0] q_q;

   // Shift register: load has priority, advancing from the seed if both.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= RESET_VAL;
      end else if (load) begin
         q_q <= advance ? lfsr_step(seed) : seed;
      end else if (advance) begin
         q_q <= lfsr_step(q_q);
      end
   end

   assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/channel_err_inj.sv
`default_nettype none
// ============================================================================
//  Module   : channel_err_inj
//  Purpose  : Registers encoder symbols and, during a measurement window,
//             XOR-corrupts selected symbols (burst or pseudo-random) while
//             counting corrupted symbols and flipped bits.
//  Revision : 1.0  initial release
// ============================================================================
module channel_err_inj #(
   parameter int          N         = 5,
   parameter int          BURST     = 8,
   parameter int          WINDOW    = 256,
   parameter logic [1:0]  ERR_MASK  = 2'b01,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input wire logic          clk,
   input wire logic          rst,
   channel_err_inj_if.slave  bus
);

   localparam int unsigned  c_burst_start_int = 2**N - BURST;
   localparam logic [N:0]   c_burst_start     = c_burst_start_int[N:0];
   localparam int unsigned  c_last_int        = WINDOW - 1;
   localparam logic [15:0]  c_last            = c_last_int[15:0];
   localparam logic [16:0]  c_pop             = {15'd0, chan_pkg::popcount2(ERR_MASK)};

   chan_pkg::state_e state_q;
   chan_pkg::mode_e  mode_q;
   logic [7:0]       thresh_q;
   logic [15:0]      sym_ct_q, sym_ct_d;
   logic [15:0]      inj_ct_q, inj_ct_d;
   logic [15:0]      bad_ct_q, bad_ct_d;
   logic             valid_q;
   logic [1:0]       sym_q;
   logic             busy_q, done_q;
   logic [15:0]      lfsr_q;

   chan_pkg::mode_e  w_mode;
   logic [7:0]       w_thresh;
   logic [15:0]      w_ct, w_lfsr, w_inj_base, w_bad_base;
   logic [16:0]      w_bad_sum;
   logic             w_accept, w_sym_valid, w_last, w_hit, w_corrupt;

   // Same-cycle start takes effect immediately: the coincident symbol is
   // index 0 and is judged with the new mode, threshold and seed.
   always_comb begin
      w_accept    = bus.start_i && (state_q != chan_pkg::RUN);
      w_mode      = w_accept ? chan_pkg::mode_e'(bus.mode_i) : mode_q;
      w_thresh    = w_accept ? bus.thresh_i : thresh_q;
      w_ct        = w_accept ? 16'd0 : sym_ct_q;
      w_lfsr      = w_accept ? LFSR_SEED : lfsr_q;
      w_sym_valid = bus.valid_i && ((state_q == chan_pkg::RUN) || w_accept);
      w_last      = w_sym_valid && (w_ct == c_last);

      w_hit = 1'b0;
      case (w_mode)
         chan_pkg::BURST: w_hit = ({1'b0, w_ct[N-1:0]} >= c_burst_start);
         chan_pkg::RAND:  w_hit = (w_lfsr[7:0] < w_thresh);
         default:         w_hit = 1'b0;
      endcase
      w_corrupt = w_sym_valid && w_hit;

      sym_ct_d   = w_sym_valid ? (w_ct + 16'd1) : w_ct;
      w_inj_base = w_accept ? 16'd0 : inj_ct_q;
      w_bad_base = w_accept ? 16'd0 : bad_ct_q;
      w_bad_sum  = {1'b0, w_bad_base} + c_pop;

      inj_ct_d = w_inj_base;
      bad_ct_d = w_bad_base;
      if (w_corrupt) begin
         if (w_inj_base != 16'hFFFF) inj_ct_d = w_inj_base + 16'd1;
         bad_ct_d = w_bad_sum[16] ? 16'hFFFF : w_bad_sum[15:0];
      end
   end

   // Run controller with registered busy/done flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= chan_pkg::IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            chan_pkg::RUN: begin
               if (w_last) begin
                  state_q <= chan_pkg::DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            chan_pkg::IDLE, chan_pkg::DONE: begin
               if (w_accept) begin
                  state_q <= w_last ? chan_pkg::DONE : chan_pkg::RUN;
                  busy_q  <= !w_last;
                  done_q  <= w_last;
               end
            end
            default: begin
               state_q <= chan_pkg::IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Symbol register, run counters and latched run configuration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         sym_q    <= 2'b00;
         sym_ct_q <= 16'd0;
         inj_ct_q <= 16'd0;
         bad_ct_q <= 16'd0;
         mode_q   <= chan_pkg::PASS;
         thresh_q <= 8'd0;
      end else begin
         valid_q  <= bus.valid_i;
         sym_q    <= w_corrupt ? (bus.sym_i ^ ERR_MASK) : bus.sym_i;
         sym_ct_q <= sym_ct_d;
         inj_ct_q <= inj_ct_d;
         bad_ct_q <= bad_ct_d;
         mode_q   <= w_mode;
         thresh_q <= w_thresh;
      end
   end

   lfsr16 #(
      .RESET_VAL (LFSR_SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (w_accept),
      .seed    (LFSR_SEED),
      .advance (w_sym_valid),
      .q       (lfsr_q)
   );

   assign bus.valid_o      = valid_q;
   assign bus.sym_o        = sym_q;
   assign bus.busy_o       = busy_q;
   assign bus.done_o       = done_q;
   assign bus.inj_ct_o     = inj_ct_q;
   assign bus.bad_bit_ct_o = bad_ct_q;

endmodule
`default_nettype wire

// File: tb/tb_channel_err_inj.sv
`default_nettype none
// ============================================================================
//  Module   : tb_channel_err_inj
//  Purpose  : Scoreboard bench for channel_err_inj (default parameters).
//  Revision : 1.0  initial release
// ============================================================================
module tb_channel_err_inj;

   typedef struct packed {
      logic        v;
      logic [1:0]  s;
      logic        busy;
      logic        done;
      logic [15:0] inj;
      logic [15:0] bad;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   channel_err_inj_if bus ();

   channel_err_inj dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model of the spec'd behaviour (default parameters).
   obs_t        exp_q[$];
   logic        m_run = 1'b0, m_done = 1'b0;
   int          m_idx = 0, m_inj = 0;
   logic [15:0] m_lfsr = 16'hACE1;
   logic [1:0]  m_mode = 2'b00;
   logic [7:0]  m_thresh = 8'd0;

   function automatic logic [15:0] ref_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.v = bus.valid_o; o.s = bus.sym_o; o.busy = bus.busy_o; o.done = bus.done_o;
      o.inj = bus.inj_ct_o; o.bad = bus.bad_bit_ct_o;
      return o;
   endfunction

   // Drive one cycle of inputs and push the expected post-edge outputs.
   task automatic drive(input logic st, input logic [1:0] md, input logic [7:0] th,
                        input logic v, input logic [1:0] s);
      logic acc, corrupt;
      int   idx;
      logic [15:0] lf;
      obs_t e;
      acc = st && !m_run;
      if (acc) begin
         m_mode = md; m_thresh = th; m_inj = 0; m_done = 1'b0;
         m_run = 1'b1; m_idx = 0; m_lfsr = 16'hACE1;
      end
      idx = m_idx; lf = m_lfsr; corrupt = 1'b0;
      if (m_run && v) begin
         if (m_mode == 2'b01) corrupt = (idx % 32) >= 24;
         else if (m_mode == 2'b10) corrupt = lf[7:0] < m_thresh;
         m_lfsr = ref_step(lf);
         m_idx = idx + 1;
         if (idx == 255) begin m_run = 1'b0; m_done = 1'b1; end
      end
      if (corrupt) m_inj = m_inj + 1;
      e.v = v; e.s = corrupt ? (s ^ 2'b01) : s; e.busy = m_run; e.done = m_done;
      e.inj = m_inj[15:0]; e.bad = m_inj[15:0];
      exp_q.push_back(e);
      bus.start_i = st; bus.mode_i = md; bus.thresh_i = th; bus.valid_i = v; bus.sym_i = s;
   endtask

   task automatic test_reset();
      obs_t got;
      bus.start_i = 0; bus.mode_i = 0; bus.thresh_i = 0; bus.valid_i = 0; bus.sym_i = 0;
      repeat (2) @(posedge clk);
      #1;
      got = observe();
      n_chk++;
      if (got !== '0) begin n_fail++; $display("FAIL reset_state: got %h want 0", got); end
      rst = 1'b0;
      drive(0, 0, 0, 1, 2'b11);
      @(posedge clk); #1;
      got = observe(); n_chk++;
      if (got !== exp_q.pop_front()) begin n_fail++; $display("FAIL idle_pass: got %h", got); end
   endtask

   task automatic test_pass();
      obs_t got, e;
      for (int i = 0; i < 300; i++) begin
         drive(i == 0, 2'b00, 8'd0, 1'b1, 2'($urandom_range(0, 3)));
         @(posedge clk); #1;
         got = observe(); e = exp_q.pop_front(); n_chk++;
         if (got !== e) begin n_fail++; $display("FAIL pass_cyc%0d: got %h want %h", i, got, e); end
      end
      n_chk++;
      if (bus.done_o !== 1'b1 || bus.inj_ct_o !== 16'd0 || bus.bad_bit_ct_o !== 16'd0) begin
         n_fail++; $display("FAIL pass_end: done %b inj %0d bad %0d want 1 0 0",
                            bus.done_o, bus.inj_ct_o, bus.bad_bit_ct_o);
      end
   endtask

   task automatic test_burst(input int gap, input string tag);
      obs_t got, e;
      int nv = 0;
      for (int c = 0; nv < 258; c++) begin
         logic v;
         v = (c % gap) == 0;
         drive(c == 0, 2'b01, 8'd0, v, 2'($urandom_range(0, 3)));
         if (v) nv++;
         @(posedge clk); #1;
         got = observe(); e = exp_q.pop_front(); n_chk++;
         if (got !== e) begin n_fail++; $display("FAIL %s_cyc%0d: got %h want %h", tag, c, got, e); end
      end
      n_chk++;
      if (bus.inj_ct_o !== 16'd64 || bus.bad_bit_ct_o !== 16'd64 || bus.done_o !== 1'b1) begin
         n_fail++; $display("FAIL %s_end: inj %0d bad %0d done %b want 64 64 1",
                            tag, bus.inj_ct_o, bus.bad_bit_ct_o, bus.done_o);
      end
   endtask

   task automatic test_random(input logic [7:0] th);
      obs_t got, e;
      for (int i = 0; i < 260; i++) begin
         drive(i == 0, 2'b10, th, 1'b1, 2'($urandom_range(0, 3)));
         @(posedge clk); #1;
         got = observe(); e = exp_q.pop_front(); n_chk++;
         if (got !== e) begin n_fail++; $display("FAIL rand%0d_cyc%0d: got %h want %h", th, i, got, e); end
      end
      n_chk++;
      if (th == 8'd0 && bus.inj_ct_o !== 16'd0) begin
         n_fail++; $display("FAIL rand0_end: inj %0d want 0", bus.inj_ct_o);
      end else if (th != 8'd0 && bus.inj_ct_o !== 16'(m_inj)) begin
         n_fail++; $display("FAIL rand_end: inj %0d want %0d", bus.inj_ct_o, m_inj);
      end
   endtask

   task automatic test_reset_mid_run();
      obs_t got, e;
      for (int i = 0; i < 100; i++) begin
         drive(i == 0, 2'b01, 8'd0, 1'b1, 2'($urandom_range(0, 3)));
         @(posedge clk); #1;
         got = observe(); e = exp_q.pop_front(); n_chk++;
         if (got !== e) begin n_fail++; $display("FAIL rstrun_cyc%0d: got %h want %h", i, got, e); end
      end
      #1 rst = 1'b1;
      #1;
      got = observe(); n_chk++;
      if (got !== '0) begin n_fail++; $display("FAIL async_reset: got %h want 0", got); end
      exp_q.delete();
      m_run = 1'b0; m_done = 1'b0; m_inj = 0; m_idx = 0; m_lfsr = 16'hACE1;
      bus.start_i = 0; bus.valid_i = 0;
      @(posedge clk); #1;
      got = observe(); n_chk++;
      if (got !== '0) begin n_fail++; $display("FAIL reset_held: got %h want 0", got); end
      rst = 1'b0;
      test_burst(1, "burst_after_rst");
   endtask

   task automatic test_start_ignored();
      obs_t got, e;
      for (int i = 0; i < 258; i++) begin
         drive(i == 0 || i == 50, (i == 50) ? 2'b10 : 2'b01, 8'd200, 1'b1, 2'($urandom_range(0, 3)));
         @(posedge clk); #1;
         got = observe(); e = exp_q.pop_front(); n_chk++;
         if (got !== e) begin n_fail++; $display("FAIL ignstart_cyc%0d: got %h want %h", i, got, e); end
      end
      n_chk++;
      if (bus.inj_ct_o !== 16'd64) begin n_fail++; $display("FAIL ignstart_end: inj %0d want 64", bus.inj_ct_o); end
      // Restart from DONE in random mode: counters clear, window restarts.
      drive(1, 2'b10, 8'd64, 1'b0, 2'b00);
      @(posedge clk); #1;
      got = observe(); e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL done_restart: got %h want %h", got, e); end
      n_chk++;
      if (bus.inj_ct_o !== 16'd0 || bus.busy_o !== 1'b1 || bus.done_o !== 1'b0) begin
         n_fail++; $display("FAIL restart_clear: inj %0d busy %b done %b want 0 1 0",
                            bus.inj_ct_o, bus.busy_o, bus.done_o);
      end
      for (int i = 0; i < 258; i++) begin
         drive(0, 2'b10, 8'd64, 1'b1, 2'($urandom_range(0, 3)));
         @(posedge clk); #1;
         got = observe(); e = exp_q.pop_front(); n_chk++;
         if (got !== e) begin n_fail++; $display("FAIL restart_cyc%0d: got %h want %h", i, got, e); end
      end
      n_chk++;
      if (bus.done_o !== 1'b1 || bus.inj_ct_o !== 16'(m_inj)) begin
         n_fail++; $display("FAIL restart_end: done %b inj %0d want 1 %0d", bus.done_o, bus.inj_ct_o, m_inj);
      end
   endtask

   initial begin
      test_reset();
      test_pass();
      test_burst(1, "burst");
      test_burst(3, "burst_sparse");
      test_random(8'd0);
      test_random(8'd64);
      test_reset_mid_run();
      test_start_ignored();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/channel_err_inj.md
# channel_err_inj

Programmable channel-impairment stage placed between the rate-1/2 convolutional encoder and the Viterbi decoder. Registers each 2-bit encoder symbol and, during a measurement window after `start_i`, flips selected bits in deterministic bursts or pseudo-random positions. It counts corrupted symbols and flipped bits so the bench can relate decoder output errors to channel error rate. Outside the window it is a 1-cycle pass-through.

## Interface
Parameters:
- `N`, 5: burst period is 2**N valid symbols.
- `BURST`, 8: corrupted symbols at the end of each period; 1 <= BURST <= 2**N.
- `WINDOW`, 256: valid symbols per measurement run; >= 1, <= 65535.
- `ERR_MASK`, 2'b01: XOR mask applied to a corrupted symbol; nonzero.
- `LFSR_SEED`, 16'hACE1: LFSR value loaded at reset and at each accepted start; nonzero.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- `mode_i`  in  2  00 pass, 01 burst, 10 random, 11 pass; sampled on accepted start.
- `thresh_i`  in  8  random-mode threshold; sampled on accepted start.
- `valid_i`  in  1  encoder symbol valid.
- `sym_i`  in  2  encoder symbol {g1,g0}.
- `valid_o`  out  1  registered `valid_i`.
- `sym_o`  out  2  registered, possibly corrupted symbol.
- `busy_o`  out  1  high in RUN.
- `done_o`  out  1  high in DONE.
- `inj_ct_o`  out  16  corrupted symbols this run.
- `bad_bit_ct_o`  out  16  flipped bits this run.

## Operation
- FSM states: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE: pass-through, no counting. `start_i` -> RUN.
- RUN: each `valid_i` cycle is one symbol with index `sym_ct` (0..WINDOW-1); `sym_ct` increments only on valid. On the valid with `sym_ct == WINDOW-1` -> DONE. `start_i` ignored.
- DONE: pass-through, counters held. `start_i` -> RUN.
- Accepted start clears `sym_ct`, `inj_ct_o`, `bad_bit_ct_o`; loads LFSR with `LFSR_SEED`; latches mode and threshold.
- Corrupt decision applies only to valid symbols in RUN:
  - burst: `sym_ct[N-1:0] >= 2**N - BURST`.
  - random: `lfsr[7:0] < thresh_lat`. LFSR is 16-bit Galois, taps 16'hB400, and advances once per valid symbol in RUN after the compare.
  - pass/11: never.
- On a corrupted symbol, `sym_o = sym_i ^ ERR_MASK`. `inj_ct_o` += 1. `bad_bit_ct_o` += popcount(ERR_MASK). Both counters saturate at 16'hFFFF.
- Mask is applied in the same cycle as the decision; no one-cycle-late mask.
- Non-valid cycles: `sym_o` still tracks `sym_i` uncorrupted. No counter or LFSR change.

## Timing
- Latency is exactly 1 cycle: `valid_o`/`sym_o` at edge k+1 reflect inputs and decision at edge k.
- Reset (asynchronous): `valid_o`=0, `sym_o`=0, `busy_o`=0, `done_o`=0, both counters 0, state IDLE, LFSR=`LFSR_SEED`. Reset mid-RUN aborts the run; no partial results are kept.
- `busy_o` rises the cycle after the accepted start. `done_o` rises the cycle after the last window symbol; that symbol's `valid_o` appears in the same cycle.
- `start_i` coincident with `valid_i`: that symbol is index 0 of the new run, and the decision uses the new mode and seed.
- The symbol after the last window symbol is never corrupted.

## Structure
- Package `chan_pkg`: `mode_e` (PASS, BURST, RAND, RSVD), `state_e` (IDLE, RUN, DONE), `LFSR_TAPS` = 16'hB400, `popcount2` function.
- Sub-module `lfsr16` with ports clk, rst, load, seed, advance, q. The rest is a single module.

## Test plan
- Mode pass, 300 symbols with continuous valid: `sym_o` equals `sym_i` delayed 1 cycle; counters stay 0; `done_o` after symbol 255.
- Burst mode with defaults: symbols 24–31, 56–63, …, 248–255 have bit0 flipped; `inj_ct_o` = 64; `bad_bit_ct_o` = 64; symbol 256 is clean.
- Burst mode with `valid_i` high every third cycle: same flipped indices as the previous case; `sym_ct` frozen on idle cycles; outputs unchanged on non-valid cycles.
- Random mode: `thresh_i` = 0 gives 0 errors. `thresh_i` = 64 matches a bench LFSR model bit-exactly, about 64 errors.
- Async reset asserted at symbol 100 of a burst run: outputs 0 immediately, state IDLE. A new start reproduces the full burst-mode result.
- `start_i` at symbol 50 of a run is ignored. `start_i` in DONE with mode RAND clears counters and starts a fresh window.
